// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and register-zero constant.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Load-use hazard compare between the load in EX and the ID sources.
// Writes to $zero never create a dependency.
import pipeline_ctrl_pkg::*;

module load_use_detector (
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] rt_ex,
  input  logic       mem_read,
  output logic       load_use
);

  // A load targeting a register read by the ID instruction
  always_comb begin
    load_use = mem_read
             & (rt_ex != REG_ZERO)
             & ((rt_ex == rs_id) | (rt_ex == rt_id));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Per-stage enable/flush sequencer for the 5-stage pipeline.
// Freeze on memory wait, flush on taken branch, bubble on load-use.
import pipeline_ctrl_pkg::*;

module pipeline_hazard_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic [4:0]       rt_ex,
  input  logic             ctrl_MemRead_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic             lu_raw;
  logic             lu;
  logic             mem_hold;
  logic             flush_evt;
  logic [TO_W-1:0]  wait_q;
  logic [TO_W-1:0]  wait_nxt;
  logic             to_q;
  logic [CNT_W-1:0] sc_q;
  logic [CNT_W-1:0] fc_q;

  load_use_detector u_lud (
    .rs_id    (rs_id),
    .rt_id    (rt_id),
    .rt_ex    (rt_ex),
    .mem_read (ctrl_MemRead_ex),
    .load_use (lu_raw)
  );

  // Hazard terms; the bubble already sits in EX after a load stall
  always_comb begin
    mem_hold = dmem_req & ~dmem_ready;
    lu       = lu_raw & (state != LOAD_STALL);
  end

  // Priority chain: memory freeze, then branch flush, then load-use
  always_comb begin
    state_nxt  = RUN;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    flush_evt  = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        state_nxt = MEM_WAIT;
      end else if (branch_taken_ex) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_evt  = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        state_nxt  = LOAD_STALL;
      end
    end
  end

  // Consecutive memory-wait cycles, saturating at the timeout
  always_comb begin
    wait_nxt = '0;
    if (mem_hold)
      wait_nxt = (wait_q == TO_MAX) ? wait_q : wait_q + 1'b1;
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
      if (wait_nxt == TO_MAX)
        to_q <= 1'b1;
    end
  end

  // Saturating stall and flush performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (!pc_en && sc_q != CNT_MAX)
        sc_q <= sc_q + 1'b1;
      if (flush_evt && fc_q != CNT_MAX)
        fc_q <= fc_q + 1'b1;
    end
  end

  // Registered status reads as cleared while reset is held
  always_comb begin
    mem_timeout = to_q & ~rst;
    stall_count = rst ? '0 : sc_q;
    flush_count = rst ? '0 : fc_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Directed hazard scenarios followed by randomized traffic.
module tb_pipeline_hazard_controller;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [4:0]       rt_ex;
  logic             mr;
  logic             br;
  logic             req;
  logic             rdy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  pipeline_hazard_controller #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .rt_ex           (rt_ex),
    .ctrl_MemRead_ex (mr),
    .branch_taken_ex (br),
    .dmem_req        (req),
    .dmem_ready      (rdy),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int          cyc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // reference model state
  bit m_after_stall = 0;
  int m_run = 0;
  bit m_to = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic step(input bit r, input int s, input int t,
                      input int e, input bit m, input bit b,
                      input bit q, input bit y);
    logic [6:0] ctl;
    bit         hold;
    bit         dep;
    rst   = r;
    rs_id = 5'(s);
    rt_id = 5'(t);
    rt_ex = 5'(e);
    mr    = m;
    br    = b;
    req   = q;
    rdy   = y;
    hold  = q && !y;
    dep   = m && e != 0 && (e == s || e == t) && !m_after_stall;
    // ctl = pc,ifid_en,ifid_flush,idex_en,idex_flush,exmem,memwb
    if (r) begin
      ctl = 7'b1101011;
      exp_q.push_back({ctl, 1'b0, 4'd0, 4'd0});
      m_after_stall = 0;
      m_run = 0;
      m_to = 0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (hold) ctl = 7'b0000000;
      else if (b) ctl = 7'b1111111;
      else if (dep) ctl = 7'b0001111;
      else ctl = 7'b1101011;
      exp_q.push_back({ctl, m_to, 4'(m_sc), 4'(m_fc)});
      if (hold || (!b && dep)) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (!hold && b) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      m_run = hold ? ((m_run < TIMEOUT) ? m_run + 1 : TIMEOUT) : 0;
      if (m_run == TIMEOUT) m_to = 1;
      m_after_stall = !hold && !b && dep;
    end
    cyc_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 1, 2, 3, 0, 0, 0, 0);
  endtask

  // monitor: compare DUT outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    logic [15:0] act;
    logic [15:0] exv;
    int          c;
    if (exp_q.size() > 0) begin
      exv = exp_q.pop_front();
      c   = cyc_q.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_en, mem_timeout, stall_count, flush_count};
      checks++;
      if (act !== exv) begin
        failures++;
        $display("FAIL cycle%0d ctl/to/sc/fc got=%b need=%b", c, act, exv);
      end
    end
  end

  initial begin
    int n;
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // load-use stall then suppressed cycle
    step(0, 5, 0, 5, 1, 0, 0, 0);
    step(0, 5, 0, 5, 1, 0, 0, 0);
    idle();
    // $zero target never stalls
    step(0, 0, 0, 0, 1, 0, 0, 0);
    // branch beats load-use
    step(0, 5, 0, 5, 1, 1, 0, 0);
    idle();
    // three wait cycles then ready
    repeat (3) step(0, 1, 2, 3, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 1, 1);
    idle();
    // timeout and its sticky behaviour
    repeat (6) step(0, 1, 2, 3, 0, 0, 1, 0);
    step(0, 1, 2, 3, 0, 0, 1, 1);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // flush counter saturation
    repeat (20) step(0, 1, 2, 3, 0, 1, 0, 0);
    idle();
    // ready exit with load-use pending, then reset mid-wait
    repeat (2) step(0, 7, 1, 7, 1, 0, 1, 0);
    step(0, 7, 1, 7, 1, 0, 1, 1);
    step(0, 7, 1, 7, 1, 0, 0, 0);
    repeat (2) step(0, 1, 2, 3, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    idle();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(59) == 0,
           $urandom_range(3), $urandom_range(3), $urandom_range(3),
           $urandom_range(1), $urandom_range(5) == 0,
           $urandom_range(3) == 0, $urandom_range(2) == 0);
    end
    idle();
    n = 0;
    while (exp_q.size() > 0 && n < 4) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain left=%0d need=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
